// File: rtl/vga_console_pkg.sv
// Shared geometry, pipeline depth and cell-format constants for the VGA text console.
// The side-band struct travels alongside each pixel from the first stage to the output mux.
package vga_console_pkg;

  localparam int COLS         = 80;
  localparam int ROWS         = 30;
  localparam int CELL_W       = 8;
  localparam int CELL_H       = 16;
  localparam int LAT          = 5;
  localparam int RGB_W        = 6;
  localparam int INV_BIT      = 7;
  localparam int ADDR_W       = 12;
  localparam int GLYPH_ADDR_W = 11;

  typedef struct packed {
    logic [2:0] px;       // pixel within the glyph row
    logic [3:0] ln;       // line within the cell
    logic       active;
    logic       cur_hit;
  } sideband_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register whose stages all load RESET_VAL on reset.
// Used to keep syncs and per-pixel side-band aligned with the memory pipeline.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RESET_VAL;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel stage: cell fetch, glyph fetch, cursor/inverse overlay and colour mux,
// with syncs delayed by the same five cycles as the pixel data.
module vga_text_renderer #(
  parameter int COLS       = vga_console_pkg::COLS,
  parameter int ROWS       = vga_console_pkg::ROWS,
  parameter int SYNC_NEG   = 1,
  parameter int BLINK_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        char_rd_en,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] glyph_addr,
  input  logic [7:0]  glyph_row,
  input  logic [5:0]  fg_color,
  input  logic [5:0]  bg_color,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic [5:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);
  import vga_console_pkg::*;

  localparam int         CNT_W    = BLINK_LOG2 + 1;
  localparam logic [9:0] H_ACTIVE = 10'(COLS * CELL_W);
  localparam logic [9:0] V_ACTIVE = 10'(ROWS * CELL_H);
  localparam logic [6:0] COL_LIM  = 7'(COLS);
  localparam logic [4:0] ROW_LIM  = 5'(ROWS);
  localparam logic       SYNC_POL = (SYNC_NEG != 0);

  logic [6:0]              col;
  logic [4:0]              row;
  logic                    active_in;
  logic                    hit_in;
  logic [ADDR_W-1:0]       cell_addr;
  sideband_t               sb_in;
  sideband_t               sb_s2;
  sideband_t               sb_s4;
  logic                    inv_s4;
  logic [1:0]              sync_d;
  logic                    char_rd_en_reg;
  logic [ADDR_W-1:0]       char_addr_reg;
  logic [GLYPH_ADDR_W-1:0] glyph_addr_reg;
  logic                    vsync_prev_reg;
  logic [CNT_W-1:0]        frame_cnt_reg;
  logic                    cur_vis;
  logic                    underline;
  logic                    pixel_bit;
  logic [RGB_W-1:0]        rgb_reg;

  assign col       = hpos[9:3];
  assign row       = vpos[8:4];
  assign active_in = (hpos < H_ACTIVE) && (vpos < V_ACTIVE);
  assign hit_in    = cursor_en && (cursor_x < COL_LIM) && (cursor_y < ROW_LIM) &&
                     (cursor_x == col) && (cursor_y == row);

  // 80 columns = 64 + 16, so the row multiply collapses to two shifted adds
  generate
    if (COLS == 80) begin : g_addr_shift
      assign cell_addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
    end else begin : g_addr_mul
      assign cell_addr = ADDR_W'(int'(row) * COLS + int'(col));
    end
  endgenerate

  assign sb_in = '{px: hpos[2:0], ln: vpos[3:0], active: active_in, cur_hit: hit_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      char_rd_en_reg <= 1'b0;
      char_addr_reg  <= '0;
    end else begin
      char_rd_en_reg <= active_in;
      if (active_in) begin
        char_addr_reg <= cell_addr;
      end
    end
  end

  vga_delay_line #(.WIDTH($bits(sideband_t)), .DEPTH(2)) u_sb_front (
    .clk(clk), .reset(reset), .din(sb_in), .dout(sb_s2)
  );

  vga_delay_line #(.WIDTH($bits(sideband_t)), .DEPTH(2)) u_sb_back (
    .clk(clk), .reset(reset), .din(sb_s2), .dout(sb_s4)
  );

  // Cell data arrives together with sb_s2, so both index the font ROM in the same stage
  always_ff @(posedge clk) begin
    if (reset) begin
      glyph_addr_reg <= '0;
    end else if (sb_s2.active) begin
      glyph_addr_reg <= {char_data[6:0], sb_s2.ln};
    end
  end

  vga_delay_line #(.WIDTH(1), .DEPTH(2)) u_inv (
    .clk(clk), .reset(reset), .din(char_data[INV_BIT]), .dout(inv_s4)
  );

  vga_delay_line #(.WIDTH(2), .DEPTH(LAT)) u_sync (
    .clk(clk), .reset(reset), .din({hsync_in, vsync_in}), .dout(sync_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      vsync_prev_reg <= vsync_in;
      if (vsync_in && !vsync_prev_reg) begin
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cur_vis   = (BLINK_LOG2 == 0) || !frame_cnt_reg[BLINK_LOG2];
  assign underline = sb_s4.cur_hit && (sb_s4.ln >= 4'd14) && cur_vis;
  assign pixel_bit = glyph_row[3'd7 - sb_s4.px] ^ inv_s4 ^ underline;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg <= '0;
    end else if (!sb_s4.active) begin
      rgb_reg <= '0;
    end else begin
      rgb_reg <= pixel_bit ? fg_color : bg_color;
    end
  end

  assign char_rd_en = char_rd_en_reg;
  assign char_addr  = char_addr_reg;
  assign glyph_addr = glyph_addr_reg;
  assign rgb        = rgb_reg;
  assign hsync_out  = sync_d[1] ^ SYNC_POL;
  assign vsync_out  = sync_d[0] ^ SYNC_POL;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench: directed scans plus randomized pixels against a per-pixel
// reference model computed from cell/glyph tables, cursor blink rules and sync delay.
module tb_vga_text_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        hsync_in, vsync_in;
  logic        char_rd_en;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [10:0] glyph_addr;
  logic [7:0]  glyph_row;
  logic [5:0]  fg_color, bg_color;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_en;
  logic [5:0]  rgb;
  logic        hsync_out, vsync_out;

  logic        char_rd_en_p;
  logic [11:0] char_addr_p;
  logic [10:0] glyph_addr_p;
  logic [5:0]  rgb_p;
  logic        hsync_p, vsync_p;

  always #5 clk = ~clk;

  vga_text_renderer #(.SYNC_NEG(1), .BLINK_LOG2(4)) u_dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_rd_en(char_rd_en), .char_addr(char_addr), .char_data(char_data),
    .glyph_addr(glyph_addr), .glyph_row(glyph_row),
    .fg_color(fg_color), .bg_color(bg_color),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Positive-polarity variant; only its syncs are checked
  vga_text_renderer #(.SYNC_NEG(0), .BLINK_LOG2(0)) u_dut_pos (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_rd_en(char_rd_en_p), .char_addr(char_addr_p), .char_data(char_data),
    .glyph_addr(glyph_addr_p), .glyph_row(glyph_row),
    .fg_color(fg_color), .bg_color(bg_color),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .rgb(rgb_p), .hsync_out(hsync_p), .vsync_out(vsync_p)
  );

  logic [7:0] char_mem  [0:4095];
  logic [7:0] glyph_mem [0:2047];

  always @(posedge clk) begin
    char_data <= char_mem[char_addr];
    glyph_row <= glyph_mem[glyph_addr];
  end

  typedef struct {
    bit         rst;
    bit         active;
    int         addr;
    int         gaddr;
    int         px;
    int         ln;
    bit         hit;
    bit         hs;
    bit         vs;
    logic [5:0] rgb_exp;
  } rec_t;

  rec_t       hist [8];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_ca = 0;
  int         exp_ga = 0;
  int         frames = 0;
  bit         prev_vs = 0;
  int         hs_low = 0;

  bit         g_rst = 1;
  bit         g_hs = 0;
  bit         g_vs = 0;
  bit         g_ce = 0;
  int         g_cx = 0;
  int         g_cy = 0;
  logic [5:0] g_fg = 6'h3F;
  logic [5:0] g_bg = 6'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One pixel clock: check outputs due now, drive this cycle's inputs, update the model
  task automatic step(input int h, input int v);
    rec_t       r;
    logic [7:0] code;
    logic [7:0] g;
    bit         b;
    bit         ul;
    int         idx;
    if (cyc >= 1) begin
      r = hist[(cyc - 1) % 8];
      if (r.rst) exp_ca = 0;
      else if (r.active) exp_ca = r.addr;
      check_eq("char_addr", char_addr, exp_ca);
      check_eq("char_rd_en", char_rd_en, r.active && !r.rst);
    end
    if (cyc >= 3) begin
      r = hist[(cyc - 3) % 8];
      if (r.rst) exp_ga = 0;
      else if (r.active) exp_ga = r.gaddr;
      check_eq("glyph_addr", glyph_addr, exp_ga);
    end
    if (cyc >= 5) begin
      r = hist[(cyc - 5) % 8];
      check_eq("rgb", rgb, r.rgb_exp);
      check_eq("hsync_out", hsync_out, !(r.hs && !r.rst));
      check_eq("vsync_out", vsync_out, !(r.vs && !r.rst));
      check_eq("hsync_pos", hsync_p, r.hs && !r.rst);
      check_eq("vsync_pos", vsync_p, r.vs && !r.rst);
    end
    if (hsync_out == 1'b0) hs_low++;

    reset     = g_rst;
    hpos      = 10'(h);
    vpos      = 10'(v);
    hsync_in  = g_hs;
    vsync_in  = g_vs;
    fg_color  = g_fg;
    bg_color  = g_bg;
    cursor_x  = 7'(g_cx);
    cursor_y  = 5'(g_cy);
    cursor_en = g_ce;

    r.rst     = g_rst;
    r.active  = (h < 640) && (v < 480);
    r.addr    = (v / 16) * 80 + h / 8;
    r.px      = h % 8;
    r.ln      = v % 16;
    code      = char_mem[r.addr % 4096];
    r.gaddr   = (code % 128) * 16 + r.ln;
    r.hit     = g_ce && (g_cx < 80) && (g_cy < 30) && (g_cx == h / 8) && (g_cy == v / 16);
    r.hs      = g_hs;
    r.vs      = g_vs;
    r.rgb_exp = 6'h00;
    hist[cyc % 8] = r;
    if (g_rst) begin
      for (int d = 0; d <= 4; d++) begin
        if (cyc - d >= 0) hist[(cyc - d) % 8].rst = 1'b1;
      end
    end

    // Colour is decided with the fg/bg and frame count seen by the output stage
    if (cyc >= 4) begin
      idx = (cyc - 4) % 8;
      r = hist[idx];
      if (!r.rst && r.active) begin
        code = char_mem[r.addr];
        g    = glyph_mem[(code % 128) * 16 + r.ln];
        b    = g[7 - r.px];
        ul   = r.hit && (r.ln >= 14) && (((frames / 16) % 2) == 0);
        hist[idx].rgb_exp = (b ^ code[7] ^ ul) ? g_fg : g_bg;
      end
    end

    if (g_rst) begin
      frames  = 0;
      prev_vs = 0;
    end else begin
      if (g_vs && !prev_vs) frames++;
      prev_vs = g_vs;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) char_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) glyph_mem[i] = 8'($urandom);
    char_mem[0] = 8'h41;
    glyph_mem[16'h41 * 16] = 8'hA5;
    for (int i = 0; i < 16; i++) glyph_mem[16'h20 * 16 + i] = 8'h00;
    char_mem[2 * 80 + 10] = 8'hA0;
    char_mem[3 * 80 + 5]  = 8'h41;

    @(posedge clk);
    #1;

    // Reset held for several cycles
    g_rst = 1;
    for (int i = 0; i < 6; i++) step(0, 0);
    g_rst = 0;

    // First cell of line 0: glyph row 0xA5 on fg 3F / bg 00
    g_fg = 6'h3F;
    g_bg = 6'h00;
    for (int h = 0; h < 16; h++) step(h, 0);

    // Inverse-video cell with blank glyph: whole cell in foreground colour
    g_fg = 6'h2A;
    g_bg = 6'h15;
    for (int v = 32; v < 48; v++)
      for (int h = 80; h < 88; h++) step(h, v);

    // Cursor at (5,3) across 34 frames from a fresh frame counter
    g_rst = 1;
    step(700, 500);
    g_rst = 0;
    g_ce = 1;
    g_cx = 5;
    g_cy = 3;
    for (int f = 0; f < 34; f++) begin
      for (int v = 61; v < 64; v++)
        for (int h = 40; h < 48; h++) step(h, v);
      g_vs = 1;
      step(700, 500);
      g_vs = 0;
      step(700, 500);
    end

    // Out-of-range cursor column is never drawn
    g_cx = 80;
    for (int h = 632; h < 640; h++) step(h, 62);
    for (int h = 40; h < 48; h++) step(h, 63);

    // Active-area corner and first blanking pixels
    step(639, 479);
    step(640, 479);
    step(639, 480);
    step(0, 479);
    step(1023, 1023);

    // 96-cycle hsync pulse on the blanking line
    for (int i = 0; i < 6; i++) step(700, 490);
    hs_low = 0;
    for (int h = 600; h < 850; h++) begin
      g_hs = (h >= 656) && (h <= 751);
      step(h, 490);
    end
    g_hs = 0;
    for (int i = 0; i < 8; i++) step(700, 490);
    check_eq("hsync_low_len", hs_low, 96);

    // Single-cycle reset in the middle of a visible line
    g_cx = 3;
    g_cy = 6;
    for (int h = 0; h < 60; h++) begin
      g_rst = (h == 20);
      step(h, 100);
    end
    g_rst = 0;

    // Randomized pixels, cursor positions, colours, syncs and occasional reset
    for (int i = 0; i < 4000; i++) begin
      int h, v;
      h = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
      v = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        g_cx = h / 8;
        g_cy = v / 16;
      end else begin
        g_cx = $urandom_range(0, 127);
        g_cy = $urandom_range(0, 31);
      end
      g_ce  = ($urandom_range(0, 7) != 0);
      g_fg  = 6'($urandom);
      g_bg  = 6'($urandom);
      g_hs  = ($urandom_range(0, 3) == 0);
      g_vs  = ($urandom_range(0, 7) == 0);
      g_rst = ($urandom_range(0, 499) == 0);
      step(h, v);
    end
    g_rst = 0;
    g_hs  = 0;
    g_vs  = 0;
    for (int i = 0; i < 6; i++) step(700, 500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
